// File: rtl/tpu_cfu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_cfu_pkg
//
// Shared constants for the TPU CFU command controller:
//   - CFU opcodes (funct3) and CONFIG sub-selects (funct7)
//   - main command FSM and buffer-ownership FSM state encodings
//   - buffer C slicing (four 32-bit slices per C word)
//   - helper that identifies opcodes which touch the global buffers or start
//     a run, i.e. the opcodes that must stall while the TPU owns the buffers
// -----------------------------------------------------------------------------
package tpu_cfu_pkg;

  // Opcodes carried in funct3
  localparam logic [2:0] OP_CONFIG  = 3'd0;
  localparam logic [2:0] OP_WRITE_A = 3'd1;
  localparam logic [2:0] OP_WRITE_B = 3'd2;
  localparam logic [2:0] OP_START   = 3'd3;
  localparam logic [2:0] OP_STATUS  = 3'd4;
  localparam logic [2:0] OP_READ_C  = 3'd5;

  // CONFIG register selectors carried in funct7
  localparam logic [6:0] CFG_K      = 7'd0;
  localparam logic [6:0] CFG_M      = 7'd1;
  localparam logic [6:0] CFG_N      = 7'd2;
  localparam logic [6:0] CFG_OFFSET = 7'd3;

  // Main command FSM
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXEC    = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Buffer-ownership FSM
  localparam logic [1:0] OWN_IDLE    = 2'd0;
  localparam logic [1:0] OWN_WAIT_HI = 2'd1;
  localparam logic [1:0] OWN_WAIT_LO = 2'd2;

  // Buffer C word layout
  localparam int C_SLICES   = 4;
  localparam int SLICE_BITS = 32;

  // Opcodes that need the host to own the buffers (or that hand them over).
  function automatic logic needs_host_buffers(input logic [2:0] funct3);
    return (funct3 == OP_WRITE_A) || (funct3 == OP_WRITE_B) ||
           (funct3 == OP_START)   || (funct3 == OP_READ_C);
  endfunction

endpackage

// File: rtl/tpu_gb_mux.sv
// -----------------------------------------------------------------------------
// tpu_gb_mux
//
// Combinational ownership mux for the global buffer A/B/C ports.
// While tpu_own is high the TPU sequencer's read indices and C write port
// reach the buffers and host writes to A/B are blocked; otherwise the
// controller's host-side registers drive the ports.
//
// Ports:
//   tpu_own                      select: 1 = sequencer, 0 = host
//   host_a_* / host_b_*          host write enable, index, data for A/B
//   host_c_index                 host read index for C
//   tpu_a_index, tpu_b_index     sequencer read indices
//   tpu_c_wr_en/index/data_in    sequencer C write port
//   gb_a_* / gb_b_* / gb_c_*     buffer ports
// -----------------------------------------------------------------------------
module tpu_gb_mux #(
  parameter int ADDR_BITS = 16,
  parameter int C_BITS    = 128
) (
  input  logic                 tpu_own,
  input  logic                 host_a_wr_en,
  input  logic [ADDR_BITS-1:0] host_a_index,
  input  logic [31:0]          host_a_data_in,
  input  logic                 host_b_wr_en,
  input  logic [ADDR_BITS-1:0] host_b_index,
  input  logic [31:0]          host_b_data_in,
  input  logic [ADDR_BITS-1:0] host_c_index,
  input  logic [ADDR_BITS-1:0] tpu_a_index,
  input  logic [ADDR_BITS-1:0] tpu_b_index,
  input  logic                 tpu_c_wr_en,
  input  logic [ADDR_BITS-1:0] tpu_c_index,
  input  logic [C_BITS-1:0]    tpu_c_data_in,
  output logic                 gb_a_wr_en,
  output logic [ADDR_BITS-1:0] gb_a_index,
  output logic [31:0]          gb_a_data_in,
  output logic                 gb_b_wr_en,
  output logic [ADDR_BITS-1:0] gb_b_index,
  output logic [31:0]          gb_b_data_in,
  output logic                 gb_c_wr_en,
  output logic [ADDR_BITS-1:0] gb_c_index,
  output logic [C_BITS-1:0]    gb_c_data_in
);

  // The sequencer only reads A/B, so write enables are forced low while it
  // owns the buffers; the data buses simply keep showing the host registers.
  assign gb_a_wr_en   = tpu_own ? 1'b0        : host_a_wr_en;
  assign gb_a_index   = tpu_own ? tpu_a_index : host_a_index;
  assign gb_a_data_in = host_a_data_in;

  assign gb_b_wr_en   = tpu_own ? 1'b0        : host_b_wr_en;
  assign gb_b_index   = tpu_own ? tpu_b_index : host_b_index;
  assign gb_b_data_in = host_b_data_in;

  // The host never writes C; it only reads results back.
  assign gb_c_wr_en   = tpu_own ? tpu_c_wr_en   : 1'b0;
  assign gb_c_index   = tpu_own ? tpu_c_index   : host_c_index;
  assign gb_c_data_in = tpu_own ? tpu_c_data_in : '0;

endmodule

// File: rtl/tpu_cfu_ctrl.sv
// -----------------------------------------------------------------------------
// tpu_cfu_ctrl
//
// CFU-side command controller and global-buffer arbiter for the 4x4 TPU.
// Decodes CPU custom instructions into run configuration (K, M, N, input
// offset), host writes to buffers A/B, a run start pulse, status polls and
// 32-bit slice reads of buffer C. One command is outstanding at a time.
//
// Ports:
//   clk, rst_n                   clock; synchronous active-low reset
//   cmd_*                        CFU command handshake, funct3/funct7, operands
//   rsp_*                        CFU response handshake and payload
//   tpu_in_valid                 one-cycle run start
//   tpu_K/M/N, tpu_input_offset  run configuration registers
//   tpu_busy                     sequencer busy
//   tpu_a/b_index, tpu_c_*       sequencer buffer ports (passed through in a run)
//   gb_a_*, gb_b_*, gb_c_*       global buffer ports
//   gb_c_data_out                buffer C read data (1-cycle synchronous read)
// -----------------------------------------------------------------------------
module tpu_cfu_ctrl
  import tpu_cfu_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 8,
  parameter int C_BITS    = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_funct3,
  input  logic [6:0]           cmd_funct7,
  input  logic [31:0]          cmd_in0,
  input  logic [31:0]          cmd_in1,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  // TPU sequencer control
  output logic                 tpu_in_valid,
  output logic [31:0]          tpu_K,
  output logic [31:0]          tpu_M,
  output logic [31:0]          tpu_N,
  output logic [DATA_BITS-1:0] tpu_input_offset,
  input  logic                 tpu_busy,
  // TPU sequencer buffer ports
  input  logic [ADDR_BITS-1:0] tpu_a_index,
  input  logic [ADDR_BITS-1:0] tpu_b_index,
  input  logic                 tpu_c_wr_en,
  input  logic [ADDR_BITS-1:0] tpu_c_index,
  input  logic [C_BITS-1:0]    tpu_c_data_in,
  // global buffer ports
  output logic                 gb_a_wr_en,
  output logic [ADDR_BITS-1:0] gb_a_index,
  output logic [31:0]          gb_a_data_in,
  output logic                 gb_b_wr_en,
  output logic [ADDR_BITS-1:0] gb_b_index,
  output logic [31:0]          gb_b_data_in,
  output logic                 gb_c_wr_en,
  output logic [ADDR_BITS-1:0] gb_c_index,
  output logic [C_BITS-1:0]    gb_c_data_in,
  input  logic [C_BITS-1:0]    gb_c_data_out
);

  logic [1:0] state;
  logic [1:0] own_state;
  logic [2:0] op;        // opcode of the command in flight
  logic [1:0] rd_slice;  // C slice selected by the READ_C in flight

  logic                 host_a_wr_en;
  logic [ADDR_BITS-1:0] host_a_index;
  logic [31:0]          host_a_data;
  logic                 host_b_wr_en;
  logic [ADDR_BITS-1:0] host_b_index;
  logic [31:0]          host_b_data;
  logic [ADDR_BITS-1:0] host_c_index;

  logic        tpu_own;
  logic        accept;
  logic        start_run;
  logic [31:0] rd_word;

  assign tpu_own = (own_state != OWN_IDLE);

  // Buffer ops and START stall during a run; CONFIG, STATUS and the unused
  // opcodes are still accepted so software can poll and pre-configure.
  assign cmd_ready = (state == ST_IDLE) &&
                     !(tpu_own && needs_host_buffers(cmd_funct3));
  assign accept    = cmd_valid && cmd_ready;
  assign start_run = accept && (cmd_funct3 == OP_START);

  // Select the requested 32-bit slice of the C word.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_SLICES; i++) begin
      if (rd_slice == i[1:0]) rd_word = gb_c_data_out[i*SLICE_BITS +: SLICE_BITS];
    end
  end

  // ---------------------------------------------------------------------------
  // Main command FSM and host-side registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is only seen at a clock edge, so it sits
    // inside the clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      state            <= ST_IDLE;
      op               <= OP_CONFIG;
      rd_slice         <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      tpu_in_valid     <= 1'b0;
      tpu_K            <= 32'd4;
      tpu_M            <= 32'd4;
      tpu_N            <= 32'd4;
      tpu_input_offset <= '0;
      host_a_wr_en     <= 1'b0;
      host_a_index     <= '0;
      host_a_data      <= '0;
      host_b_wr_en     <= 1'b0;
      host_b_index     <= '0;
      host_b_data      <= '0;
      host_c_index     <= '0;
    end else begin
      // Single-cycle strobes fall back to zero unless set below.
      host_a_wr_en <= 1'b0;
      host_b_wr_en <= 1'b0;
      tpu_in_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= cmd_funct3;
            state <= ST_EXEC;
            // Side effects happen at the accept edge so write strobes and the
            // start pulse are high during the cycle right after it.
            case (cmd_funct3)
              OP_CONFIG: begin
                case (cmd_funct7)
                  CFG_K:      tpu_K            <= cmd_in0;
                  CFG_M:      tpu_M            <= cmd_in0;
                  CFG_N:      tpu_N            <= cmd_in0;
                  CFG_OFFSET: tpu_input_offset <= cmd_in0[DATA_BITS-1:0];
                  default: ;
                endcase
              end
              OP_WRITE_A: begin
                host_a_wr_en <= 1'b1;
                host_a_index <= cmd_in0[ADDR_BITS-1:0];
                host_a_data  <= cmd_in1;
              end
              OP_WRITE_B: begin
                host_b_wr_en <= 1'b1;
                host_b_index <= cmd_in0[ADDR_BITS-1:0];
                host_b_data  <= cmd_in1;
              end
              OP_START:   tpu_in_valid <= 1'b1;
              OP_READ_C: begin
                host_c_index <= cmd_in0[ADDR_BITS-1:0];
                rd_slice     <= cmd_in1[1:0];
              end
              default: ;
            endcase
          end
        end

        ST_EXEC: begin
          if (op == OP_READ_C) begin
            // The buffer samples host_c_index on this edge; data is
            // available one cycle later.
            state <= ST_RD_WAIT;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= (op == OP_STATUS) ? {30'b0, tpu_own, tpu_busy} : 32'd0;
            state     <= ST_RESP;
          end
        end

        ST_RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= rd_word;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer ownership: taken on START, released once the sequencer has been
  // seen busy and then idle again. Waiting for the rising edge first covers
  // the gap between the start pulse and the sequencer raising tpu_busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_state <= OWN_IDLE;
    end else begin
      case (own_state)
        OWN_IDLE:    if (start_run) own_state <= OWN_WAIT_HI;
        OWN_WAIT_HI: if (tpu_busy)  own_state <= OWN_WAIT_LO;
        OWN_WAIT_LO: if (!tpu_busy) own_state <= OWN_IDLE;
        default:     own_state <= OWN_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer port arbitration
  // ---------------------------------------------------------------------------
  tpu_gb_mux #(
    .ADDR_BITS (ADDR_BITS),
    .C_BITS    (C_BITS)
  ) u_gb_mux (
    .tpu_own        (tpu_own),
    .host_a_wr_en   (host_a_wr_en),
    .host_a_index   (host_a_index),
    .host_a_data_in (host_a_data),
    .host_b_wr_en   (host_b_wr_en),
    .host_b_index   (host_b_index),
    .host_b_data_in (host_b_data),
    .host_c_index   (host_c_index),
    .tpu_a_index    (tpu_a_index),
    .tpu_b_index    (tpu_b_index),
    .tpu_c_wr_en    (tpu_c_wr_en),
    .tpu_c_index    (tpu_c_index),
    .tpu_c_data_in  (tpu_c_data_in),
    .gb_a_wr_en     (gb_a_wr_en),
    .gb_a_index     (gb_a_index),
    .gb_a_data_in   (gb_a_data_in),
    .gb_b_wr_en     (gb_b_wr_en),
    .gb_b_index     (gb_b_index),
    .gb_b_data_in   (gb_b_data_in),
    .gb_c_wr_en     (gb_c_wr_en),
    .gb_c_index     (gb_c_index),
    .gb_c_data_in   (gb_c_data_in)
  );

endmodule
